alu_req_arbiter: RTL and testbench

- Shares one ALU_DESIGN instance between two independent requesters (port 0, port 1).
- Arbitrates round-robin and drives the ALU operand/control ports for one transaction at a time.
- Waits the command-dependent ALU latency, captures the results, and returns them on a response channel tagged with the requester id.
- Sits between stimulus/agent-side sources and the ALU in the top level.

---
 rtl/alu_req_arbiter_if.sv | 70 +++++++
 rtl/alu_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Purpose: signal bundle around alu_req_arbiter (two requesters, one ALU, one response channel).
// Latency: none; this is a plain signal container.
// Backpressure: carried by the req0/req1 valid/ready and rsp valid/ready pairs.
// Ports: req0_*/req1_* command channels, alu_* operand/control outputs and ALU result inputs,
//        rsp_* tagged response channel. Modport slave is the arbiter's view, master the environment's.
interface alu_req_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    // requester 0
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_opa;
    logic [WIDTH-1:0]       req0_opb;
    logic [CMD_WIDTH-1:0]   req0_cmd;
    logic                   req0_mode;
    logic                   req0_cin;
    // requester 1
    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_opa;
    logic [WIDTH-1:0]       req1_opb;
    logic [CMD_WIDTH-1:0]   req1_cmd;
    logic                   req1_mode;
    logic                   req1_cin;
    // ALU drive side
    logic                   alu_ce;
    logic [1:0]             alu_inp_valid;
    logic [WIDTH-1:0]       alu_opa;
    logic [WIDTH-1:0]       alu_opb;
    logic [CMD_WIDTH-1:0]   alu_cmd;
    logic                   alu_mode;
    logic                   alu_cin;
    // ALU result side
    logic [2*WIDTH-1:0]     alu_res;
    logic                   alu_err;
    logic                   alu_cout;
    logic                   alu_oflow;
    logic                   alu_g;
    logic                   alu_l;
    logic                   alu_e;
    // response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [2*WIDTH-1:0]     rsp_res;
    logic [5:0]             rsp_flags;

    modport slave (
        input  req0_valid, req0_opa, req0_opb, req0_cmd, req0_mode, req0_cin,
        output req0_ready,
        input  req1_valid, req1_opa, req1_opb, req1_cmd, req1_mode, req1_cin,
        output req1_ready,
        output alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin,
        input  alu_res, alu_err, alu_cout, alu_oflow, alu_g, alu_l, alu_e,
        output rsp_valid, rsp_id, rsp_res, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_opa, req0_opb, req0_cmd, req0_mode, req0_cin,
        input  req0_ready,
        output req1_valid, req1_opa, req1_opb, req1_cmd, req1_mode, req1_cin,
        input  req1_ready,
        input  alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin,
        output alu_res, alu_err, alu_cout, alu_oflow, alu_g, alu_l, alu_e,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Purpose: round-robin share of one ALU between two requesters, one transaction in flight.
// Latency: issue one cycle after accept; response lat+1 cycles after issue (lat by command).
// Backpressure: reqN_ready only in IDLE; a stalled response (rsp_ready low) parks the FSM in RESP.
// Ports: CLK, RST (sync, active-high); bus.slave carries req0/req1 command channels,
//        alu_* drive/result signals and the rsp_* response channel tagged with the requester id.
module alu_req_arbiter #(
    parameter int WIDTH       = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int LATENCY     = 1,
    parameter int MUL_LATENCY = 2
) (
    input  logic             CLK,
    input  logic             RST,
    alu_req_arbiter_if.slave bus
);
    localparam int MAX_LAT = (LATENCY > MUL_LATENCY) ? LATENCY : MUL_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    // The counter holds the number of WAIT cycles still to go after the current one.
    localparam logic [CNT_W-1:0]     LAT_LD   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]     MUL_LD   = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CMD_WIDTH-1:0] CMD_MUL9 = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] CMD_MULA = CMD_WIDTH'(10);

    typedef struct packed {
        logic [WIDTH-1:0]     opa;
        logic [WIDTH-1:0]     opb;
        logic [CMD_WIDTH-1:0] cmd;
        logic                 mode;
        logic                 cin;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state;
    state_t               next_state;
    req_t                 req0_pay;
    req_t                 req1_pay;
    req_t                 pay;
    logic                 pay_id;
    logic                 last_grant;
    logic [CNT_W-1:0]     cnt;
    logic                 grant0;
    logic                 grant1;
    logic                 xfer;
    logic                 capture;
    logic                 is_mul;
    logic                 ce;
    logic                 rsp_vld_c;
    logic                 ready0;
    logic                 ready1;
    logic                 rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_res_q;
    logic [5:0]           rsp_flags_q;

    assign req0_pay = {bus.req0_opa, bus.req0_opb, bus.req0_cmd, bus.req0_mode, bus.req0_cin};
    assign req1_pay = {bus.req1_opa, bus.req1_opb, bus.req1_cmd, bus.req1_mode, bus.req1_cin};

    // Requester 1 wins when alone, or when both ask and requester 0 was granted last.
    // last_grant resets to 1 so requester 0 is favoured first.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign grant0 = bus.req0_valid && !grant1;

    assign is_mul = pay.mode && ((pay.cmd == CMD_MUL9) || (pay.cmd == CMD_MULA));

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and per-state strobes
    always_comb begin
        next_state = state;
        ce         = 1'b0;
        rsp_vld_c  = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                ready0 = grant0;
                ready1 = grant1;
                if (grant0 || grant1) begin
                    xfer       = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                ce         = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                ce = 1'b1;
                if (cnt == '0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_vld_c = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Payload latch, arbitration pointer, latency counter and response capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pay         <= '0;
            pay_id      <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            rsp_id_q    <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            if (xfer) begin
                pay        <= grant1 ? req1_pay : req0_pay;
                pay_id     <= grant1;
                last_grant <= grant1;
            end
            if (state == ISSUE) begin
                cnt <= is_mul ? MUL_LD : LAT_LD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_id_q    <= pay_id;
                rsp_res_q   <= bus.alu_res;
                rsp_flags_q <= {bus.alu_err, bus.alu_cout, bus.alu_oflow,
                                bus.alu_g, bus.alu_l, bus.alu_e};
            end
        end
    end

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.alu_ce        = ce;
    assign bus.alu_inp_valid = {2{ce}};
    // Operand/control lines follow the latched payload, so they hold between transactions.
    assign bus.alu_opa       = pay.opa;
    assign bus.alu_opb       = pay.opb;
    assign bus.alu_cmd       = pay.cmd;
    assign bus.alu_mode      = pay.mode;
    assign bus.alu_cin       = pay.cin;
    assign bus.rsp_valid     = rsp_vld_c;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_res       = rsp_res_q;
    assign bus.rsp_flags     = rsp_flags_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Purpose: self-checking bench for alu_req_arbiter; the bench also plays the ALU.
// Latency: the reference model predicts accept/issue/response cycles from the command timing rules.
// Backpressure: random requesters and a random rsp_ready consumer exercise stalls and drops.
module tb_alu_req_arbiter;
    localparam int WIDTH       = 8;
    localparam int CMD_WIDTH   = 4;
    localparam int LATENCY     = 1;
    localparam int MUL_LATENCY = 2;

    typedef struct packed {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
    } pay_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    alu_req_arbiter_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

    alu_req_arbiter #(
        .WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .LATENCY(LATENCY), .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: who owns the ALU, since when, with what
    bit   m_busy = 0;
    int   m_xcyc = 0;
    int   m_lat  = 1;
    bit   m_id   = 0;
    bit   m_last = 1;
    pay_t m_pay  = '0;
    bit   acc0, acc1;

    // observation logs taken from the DUT for directed checks
    int          xfer_log[$];
    int          rise_log[$];
    logic        id_log[$];
    logic [15:0] res_log[$];
    logic [5:0]  flag_log[$];
    int          ce_cnt, r0_cnt, r1_cnt, rv_cnt;
    bit          prev_rv;
    logic        last_r0, last_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // behavioural ALU: {err, cout, oflow, g, l, e, res[15:0]}
    function automatic logic [21:0] alu_fn(input pay_t p);
        logic [15:0] r;
        logic err, cout, of, g, l, e;
        r = '0; err = 0; cout = 0; of = 0; g = 0; l = 0; e = 0;
        if (p.mode) begin
            case (p.cmd)
                4'd0:  begin r = 16'(p.opa) + 16'(p.opb); cout = r[8]; end
                4'd1:  begin r = 16'(p.opa) - 16'(p.opb); of = (p.opa < p.opb); end
                4'd2:  begin r = 16'(p.opa) + 16'(p.opb) + 16'(p.cin); cout = r[8]; end
                4'd8:  begin g = (p.opa > p.opb); l = (p.opa < p.opb); e = (p.opa == p.opb); end
                4'd9:  r = (16'(p.opa) + 16'd1) * (16'(p.opb) + 16'd1);
                4'd10: r = (16'(p.opa) << 1) * 16'(p.opb);
                default: err = 1'b1;
            endcase
        end else begin
            case (p.cmd)
                4'd0:    r = 16'(p.opa & p.opb);
                4'd1:    r = 16'(p.opa | p.opb);
                4'd2:    r = 16'(p.opa ^ p.opb);
                default: err = 1'b1;
            endcase
        end
        return {err, cout, of, g, l, e, r};
    endfunction

    function automatic int lat_of(input pay_t p);
        return (p.mode && (p.cmd == 4'd9 || p.cmd == 4'd10)) ? MUL_LATENCY : LATENCY;
    endfunction

    function automatic pay_t req_pay(input bit id);
        if (id) return {bus.req1_opa, bus.req1_opb, bus.req1_cmd, bus.req1_mode, bus.req1_cin};
        return {bus.req0_opa, bus.req0_opb, bus.req0_cmd, bus.req0_mode, bus.req0_cin};
    endfunction

    function automatic pay_t rand_pay();
        pay_t p;
        p.opa  = 8'($urandom);
        p.opb  = 8'($urandom);
        p.cmd  = ($urandom_range(0, 2) == 0) ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        p.mode = 1'($urandom);
        p.cin  = 1'($urandom);
        return p;
    endfunction

    task automatic set_req(input bit id, input bit v, input pay_t p);
        if (id) begin
            bus.req1_valid = v; bus.req1_opa = p.opa; bus.req1_opb = p.opb;
            bus.req1_cmd = p.cmd; bus.req1_mode = p.mode; bus.req1_cin = p.cin;
        end else begin
            bus.req0_valid = v; bus.req0_opa = p.opa; bus.req0_opb = p.opb;
            bus.req0_cmd = p.cmd; bus.req0_mode = p.mode; bus.req0_cin = p.cin;
        end
    endtask

    // The true result is presented only in the cycle the arbiter must sample it.
    task automatic drive_alu();
        logic [21:0] fr;
        fr = alu_fn(m_pay);
        if (!(m_busy && (cyc - m_xcyc) == 1 + m_lat))
            fr = fr ^ (22'($urandom) | 22'd1);
        {bus.alu_err, bus.alu_cout, bus.alu_oflow, bus.alu_g, bus.alu_l, bus.alu_e, bus.alu_res} = fr;
    endtask

    task automatic check_cycle();
        bit v0, v1, g, er0, er1, ece, erv;
        int d;
        logic [21:0] fr;
        acc0 = 0; acc1 = 0;
        if (RST) begin
            m_busy = 0; m_last = 1; m_pay = '0; prev_rv = 0;
            return;
        end
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        er0 = 0; er1 = 0; ece = 0; erv = 0;
        d = cyc - m_xcyc;
        if (!m_busy) begin
            g   = (v0 && v1) ? !m_last : v1;
            er0 = v0 && !g;
            er1 = v1 && g;
        end else if (d <= 1 + m_lat) begin
            ece = 1;
        end else begin
            erv = 1;
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(er0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(er1));
        chk("alu_ce", 32'(bus.alu_ce), 32'(ece));
        chk("alu_inp_valid", 32'(bus.alu_inp_valid), ece ? 32'd3 : 32'd0);
        chk("alu_opa", 32'(bus.alu_opa), 32'(m_pay.opa));
        chk("alu_opb", 32'(bus.alu_opb), 32'(m_pay.opb));
        chk("alu_cmd", 32'(bus.alu_cmd), 32'(m_pay.cmd));
        chk("alu_mode", 32'(bus.alu_mode), 32'(m_pay.mode));
        chk("alu_cin", 32'(bus.alu_cin), 32'(m_pay.cin));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
        if (erv) begin
            fr = alu_fn(m_pay);
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("rsp_res", 32'(bus.rsp_res), 32'(fr[15:0]));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(fr[21:16]));
        end
        if (bus.alu_ce === 1'b1) ce_cnt++;
        if (bus.req0_ready === 1'b1) r0_cnt++;
        if (bus.req1_ready === 1'b1) r1_cnt++;
        if (bus.rsp_valid === 1'b1) rv_cnt++;
        if (bus.rsp_valid === 1'b1 && !prev_rv) rise_log.push_back(cyc);
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            id_log.push_back(bus.rsp_id);
            res_log.push_back(bus.rsp_res);
            flag_log.push_back(bus.rsp_flags);
        end
        prev_rv = (bus.rsp_valid === 1'b1);
        last_r0 = bus.req0_ready;
        last_r1 = bus.req1_ready;
        if (!m_busy) begin
            if (er0 || er1) begin
                m_busy = 1; m_xcyc = cyc; m_id = er1; m_last = er1;
                m_pay  = req_pay(er1); m_lat = lat_of(m_pay);
                acc0   = er0; acc1 = er1;
                xfer_log.push_back(cyc);
            end
        end else if (erv && bus.rsp_ready) begin
            m_busy = 0;
        end
    endtask

    task automatic cycle();
        drive_alu();
        @(negedge CLK);
        check_cycle();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        xfer_log.delete(); rise_log.delete(); id_log.delete(); res_log.delete(); flag_log.delete();
        ce_cnt = 0; r0_cnt = 0; r1_cnt = 0; rv_cnt = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_req(0, 0, '0);
        set_req(1, 0, '0);
        bus.rsp_ready = 1'b1;
        cycle();
        RST = 1'b0;
        clear_logs();
    endtask

    // keep=1: requester re-arms with a fresh payload after each accept; keep=0: one shot.
    task automatic run(input int n, input bit keep);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (acc0) set_req(0, keep, keep ? rand_pay() : pay_t'('0));
            if (acc1) set_req(1, keep, keep ? rand_pay() : pay_t'('0));
        end
    endtask

    task automatic rand_req(input bit id);
        bit v, a;
        v = id ? bus.req1_valid : bus.req0_valid;
        a = id ? acc1 : acc0;
        if (a || !v) begin
            if ($urandom_range(0, 1) == 1) set_req(id, 1, rand_pay());
            else set_req(id, 0, '0);
        end else if ($urandom_range(0, 19) == 0) begin
            set_req(id, 0, '0);
        end
    endtask

    initial begin
        int n;
        // reset state
        do_reset();
        cycle();
        chk("rst_rsp_res", 32'(bus.rsp_res), 32'd0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);

        // single ADD from req0
        do_reset();
        set_req(0, 1, '{opa: 8'd5, opb: 8'd3, cmd: 4'd0, mode: 1'b1, cin: 1'b0});
        run(10, 0);
        chk("add_r0_cycles", 32'(r0_cnt), 32'd1);
        chk("add_ce_cycles", 32'(ce_cnt), 32'd2);
        chk("add_rsp_count", 32'(res_log.size()), 32'd1);
        if (res_log.size() > 0 && rise_log.size() > 0 && xfer_log.size() > 0) begin
            chk("add_lat", 32'(rise_log[0] - xfer_log[0]), 32'd3);
            chk("add_res", 32'(res_log[0]), 32'd8);
            chk("add_flags", 32'(flag_log[0]), 32'd0);
            chk("add_id", 32'(id_log[0]), 32'd0);
        end

        // both requesters valid continuously: grants alternate starting with 0
        do_reset();
        set_req(0, 1, rand_pay());
        set_req(1, 1, rand_pay());
        run(40, 1);
        set_req(0, 0, '0);
        set_req(1, 0, '0);
        run(10, 0);
        chk("alt_count_ge4", 32'(id_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < id_log.size(); i++)
            chk("alt_id", 32'(id_log[i]), 32'(i % 2));

        // multiply uses the multiply latency
        do_reset();
        set_req(0, 1, '{opa: 8'd4, opb: 8'd6, cmd: 4'd9, mode: 1'b1, cin: 1'b0});
        run(10, 0);
        chk("mul_rsp_count", 32'(res_log.size()), 32'd1);
        if (res_log.size() > 0 && rise_log.size() > 0 && xfer_log.size() > 0) begin
            chk("mul_lat", 32'(rise_log[0] - xfer_log[0]), 32'd4);
            chk("mul_res", 32'(res_log[0]), 32'd35);
        end

        // response stalled 10 cycles while req1 waits
        do_reset();
        bus.rsp_ready = 1'b0;
        set_req(0, 1, '{opa: 8'd7, opb: 8'd2, cmd: 4'd1, mode: 1'b1, cin: 1'b0});
        set_req(1, 1, '{opa: 8'd9, opb: 8'd9, cmd: 4'd8, mode: 1'b1, cin: 1'b0});
        n = 0;
        while (rise_log.size() == 0 && n < 20) begin
            cycle();
            if (acc0) set_req(0, 0, '0);
            n++;
        end
        chk("stall_rsp_seen", 32'(rise_log.size()), 32'd1);
        rv_cnt = 0; r1_cnt = 0;
        run(10, 0);
        chk("stall_rv_cycles", 32'(rv_cnt), 32'd10);
        chk("stall_r1_cycles", 32'(r1_cnt), 32'd0);
        bus.rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("stall_then_r1", 32'(last_r1), 32'd1);
        if (acc1) set_req(1, 0, '0);
        run(10, 0);

        // reset during WAIT abandons the transaction
        do_reset();
        set_req(0, 1, '{opa: 8'd1, opb: 8'd2, cmd: 4'd0, mode: 1'b1, cin: 1'b0});
        n = 0;
        while (!acc0 && n < 10) begin
            cycle();
            n++;
        end
        chk("rst_wait_accepted", 32'(acc0), 32'd1);
        set_req(0, 0, '0);
        cycle();
        chk("rst_wait_in_wait", 32'(bus.alu_ce), 32'd1);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        cycle();
        chk("rst_wait_rsp_res", 32'(bus.rsp_res), 32'd0);
        chk("rst_wait_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rst_wait_alu_opa", 32'(bus.alu_opa), 32'd0);
        chk("rst_wait_alu_ce", 32'(bus.alu_ce), 32'd0);
        run(5, 0);
        chk("rst_wait_no_rsp", 32'(rise_log.size()), 32'd0);
        set_req(0, 1, rand_pay());
        set_req(1, 1, rand_pay());
        cycle();
        chk("rst_wait_grant0", 32'(last_r0), 32'd1);
        chk("rst_wait_not1", 32'(last_r1), 32'd0);
        if (acc0) set_req(0, 0, '0);
        run(20, 0);

        // overflow on ADD
        do_reset();
        set_req(0, 1, '{opa: 8'hFF, opb: 8'h01, cmd: 4'd0, mode: 1'b1, cin: 1'b0});
        run(10, 0);
        chk("ovf_rsp_count", 32'(res_log.size()), 32'd1);
        if (res_log.size() > 0) begin
            chk("ovf_res", 32'(res_log[0]), 32'h100);
            chk("ovf_flags", 32'(flag_log[0]), 32'b010000);
        end

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle();
            rand_req(0);
            rand_req(1);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            RST = m_busy && ($urandom_range(0, 99) == 0);
        end
        RST = 1'b0;
        set_req(0, 0, '0);
        set_req(1, 0, '0);
        bus.rsp_ready = 1'b1;
        run(10, 0);
        chk("drain_idle", 32'(bus.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
